alu_md_ctrl: RTL and testbench
==============================

// Module: alu_md_ctrl
// PURPOSE
//  ALU decoder extended with the MIPS mult/div family. Combinationally maps aluop/funct to a 4-bit
//  alucontrol. Runs an iterative multiply/divide sequencer that owns the HI/LO registers.
//  Raises a stall to the datapath while a mult/div is in flight. Replaces the 3-bit decoder.
// PARAMETERS
//  WIDTH  32  operand / HI / LO width; one iteration per cycle, WIDTH iterations per operation
// PORTS
//  clk         in   1      system clock, all state on posedge
//  reset       in   1      synchronous, active-high
//  en          in   1      instruction in decode is valid (not bubbled/flushed)
//  aluop       in   2      from main decoder: 00 add, 01 sub, 10 R-type (funct), 11 or
//  funct       in   6      instruction funct field
//  srca        in   WIDTH  rs operand
//  srcb        in   WIDTH  rt operand
//  alucontrol  out  4      ALU op select (combinational)
//  illegal     out  1      unknown funct with aluop=10
//  md_sel      out  1      mfhi/mflo decoded: writeback takes md_result
//  md_result   out  WIDTH  HI (mfhi) else LO
//  stall       out  1      hold PC/IF/ID this cycle
//  busy        out  1      sequencer not IDLE
//  hi, lo      out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  alucontrol codes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0110 sub, 0111 slt,
//   1000 sltu, 1001 sll, 1010 srl, 1011 sra, 1111 none.
//  aluop 00->0010, 01->0110, 11->0001. aluop 10 decodes funct:
//   100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor,
//   101010 slt, 101011 sltu, 000000 sll, 000010 srl, 000011 sra.
//   md funct 010000-010011, 011000-011011 -> 1111, illegal=0. Any other funct -> 1111, illegal=1.
//  md ops (aluop=10 only): 011000 mult, 011001 multu, 011010 div, 011011 divu,
//   010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: with en & mult/div, latch |srca|,|srcb| (signed ops) or raw values, plus result-sign flags.
//    Clear the 6-bit-min iteration counter. Go to RUN. This start cycle itself is not stalled.
//   RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//    After WIDTH steps, go to FIX.
//   FIX: apply sign correction, write HI/LO, go to IDLE.
//   busy is high for exactly WIDTH+1 cycles after the accepting edge.
//  Results: mul gives {HI,LO} = 2*WIDTH-bit product. div gives LO=quotient, HI=remainder.
//   Signed div: quotient negated if operand signs differ; remainder takes the dividend's sign.
//  Divide by zero: LO = all ones, HI = srca (signed and unsigned). No exception.
//  Signed overflow (min/-1): LO = min, HI = 0 (falls out of abs/negate path).
//  mthi/mtlo: when en & !busy, HI/LO <= srca on the next edge.
//  stall = busy & en & (any md op). A stalled md op is not accepted. It is re-presented and
//   accepted on the first cycle busy=0. A new mult/div never overwrites an in-flight one.
//  Non-md instructions never stall while busy (independent instructions overlap).
//  md_sel = en & aluop=10 & (mfhi|mflo). md_result is valid when md_sel & !stall.
//  en=0: decode outputs still driven; no start, no mthi/mtlo, stall=0.
//  reset (including mid-operation): state IDLE, abort op, hi=lo=0, counter 0, busy=0, stall=0.
//  alucontrol/illegal/md_sel are purely combinational, with no reset dependence.
// TESTING (WIDTH=32)
//  1 aluop=00 -> 0010; aluop=10 funct=100111 -> 0100; funct=111111 -> 1111, illegal=1.
//  2 mult 0xFFFFFFFE*3 -> busy 33 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA;
//    multu same -> hi=0x00000002 lo=0xFFFFFFFA.
//  3 div -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 7/0 -> lo=0xFFFFFFFF hi=0x00000007.
//  4 mflo 5 cycles after mult start -> stall=1 until busy falls;
//    next cycle md_sel=1, md_result=lo, stall=0; add issued mid-op -> stall=0.
//  5 reset at RUN cycle 10 -> next cycle busy=0, hi=lo=0; following mult accepted, completes normally.
//  6 mthi srca=0x1234 while idle -> hi=0x1234 next edge;
//    divu presented while busy -> stall=1, accepted the cycle busy drops.

Source files
------------

// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl
//   ALU control decoder with the MIPS mult/div family attached. The aluop/funct
//   pair is decoded combinationally into a 4-bit ALU select. An iterative
//   sequencer owns the architectural HI/LO registers and performs one shift-add
//   (multiply) or restoring shift-subtract (divide) step per cycle.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_en                decode-stage instruction is valid
//   i_aluop, i_funct    main decoder op class and R-type funct field
//   i_srca, i_srcb      rs / rt operands
//   o_alucontrol        ALU operation select (combinational)
//   o_illegal           unknown funct with aluop=10
//   o_md_sel            mfhi/mflo in decode: writeback takes o_md_result
//   o_md_result         HI for mfhi, LO otherwise
//   o_stall             hold PC/IF/ID this cycle
//   o_busy              sequencer is not idle
//   o_hi, o_lo          architectural HI/LO
module alu_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_aluop,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic [3:0]       o_alucontrol,
  output logic             o_illegal,
  output logic             o_md_sel,
  output logic [WIDTH-1:0] o_md_result,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // Counter must hold WIDTH-1; never narrower than 6 bits.
  localparam int CNTW = ($clog2(WIDTH) > 6) ? $clog2(WIDTH) : 6;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 r_state, w_nextState;
  logic [CNTW-1:0]        r_cnt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_q;
  logic                   r_isDiv, r_negQ, r_negR, r_divZero;
  logic [WIDTH-1:0]       r_hi, r_lo;

  logic                   w_rtype, w_mdFunct, w_mulDivFunct, w_signedOp;
  logic                   w_start, w_mtHi, w_mtLo;
  logic [WIDTH-1:0]       w_absA, w_absB;
  logic [WIDTH:0]         w_sum, w_shifted, w_diff;
  logic [2*WIDTH-1:0]     w_prod, w_prodFix;
  logic [WIDTH-1:0]       w_quot, w_rem;

  // Funct-field classification shared by decode, stall and sequencer start.
  always_comb begin
    w_rtype       = (i_aluop == 2'b10);
    w_mdFunct     = (i_funct[5:2] == 4'b0100) || (i_funct[5:2] == 4'b0110);
    w_mulDivFunct = (i_funct[5:2] == 4'b0110);
    w_signedOp    = ~i_funct[0];
  end

  // ALU select decode; md functs map to "none" but are not illegal.
  always_comb begin
    o_alucontrol = 4'b1111;
    o_illegal    = 1'b0;
    case (i_aluop)
      2'b00: o_alucontrol = 4'b0010;
      2'b01: o_alucontrol = 4'b0110;
      2'b11: o_alucontrol = 4'b0001;
      default: begin
        case (i_funct)
          6'b100000, 6'b100001: o_alucontrol = 4'b0010;
          6'b100010, 6'b100011: o_alucontrol = 4'b0110;
          6'b100100:            o_alucontrol = 4'b0000;
          6'b100101:            o_alucontrol = 4'b0001;
          6'b100110:            o_alucontrol = 4'b0011;
          6'b100111:            o_alucontrol = 4'b0100;
          6'b101010:            o_alucontrol = 4'b0111;
          6'b101011:            o_alucontrol = 4'b1000;
          6'b000000:            o_alucontrol = 4'b1001;
          6'b000010:            o_alucontrol = 4'b1010;
          6'b000011:            o_alucontrol = 4'b1011;
          default: begin
            o_alucontrol = 4'b1111;
            o_illegal    = ~w_mdFunct;
          end
        endcase
      end
    endcase
  end

  // Handshake with the datapath. Any md op waits while the sequencer runs;
  // ordinary instructions flow past it.
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_stall     = o_busy & i_en & w_rtype & w_mdFunct;
    o_md_sel    = i_en & w_rtype & (i_funct[5:2] == 4'b0100) & ~i_funct[0];
    o_md_result = (i_funct == F_MFHI) ? r_hi : r_lo;
    o_hi        = r_hi;
    o_lo        = r_lo;
    w_start     = (r_state == IDLE) & i_en & w_rtype & w_mulDivFunct;
    w_mtHi      = i_en & ~o_busy & w_rtype & (i_funct == F_MTHI);
    w_mtLo      = i_en & ~o_busy & w_rtype & (i_funct == F_MTLO);
  end

  // Operands are reduced to magnitudes so the core iterates unsigned only.
  // The most negative value maps onto itself, which as an unsigned magnitude
  // is exactly right; that is what makes min/-1 come out as LO=min, HI=0.
  always_comb begin
    w_absA    = (w_signedOp & i_srca[WIDTH-1]) ? -i_srca : i_srca;
    w_absB    = (w_signedOp & i_srcb[WIDTH-1]) ? -i_srcb : i_srcb;
    w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_shifted = {r_acc, r_q[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, r_a};
    w_prod    = {r_acc, r_q};
    w_prodFix = r_negQ ? -w_prod : w_prod;
    w_quot    = r_divZero ? {WIDTH{1'b1}} : (r_negQ ? -r_q : r_q);
    w_rem     = r_negR ? -r_acc : r_acc;
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic: WIDTH RUN cycles, then one FIX cycle for sign repair.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = RUN;
      RUN:     if (r_cnt == CNTW'(WIDTH-1)) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Iteration datapath and HI/LO. Multiply keeps {acc,q} as the running
  // product with the multiplier shifting out of q; divide keeps the partial
  // remainder in acc while quotient bits shift into q.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_a       <= w_absB;
            r_q       <= w_absA;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_isDiv   <= i_funct[1];
            r_negQ    <= w_signedOp & (i_srca[WIDTH-1] ^ i_srcb[WIDTH-1]);
            r_negR    <= w_signedOp & i_srca[WIDTH-1];
            r_divZero <= (i_srcb == '0);
          end
          if (w_mtHi) r_hi <= i_srca;
          if (w_mtLo) r_lo <= i_srca;
        end
        RUN: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (r_isDiv) begin
            r_acc <= w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            {r_acc, r_q} <= {w_sum, r_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (r_isDiv) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb_alu_md_ctrl
//   Directed bench for alu_md_ctrl (WIDTH=32): decode table, mult/div results,
//   busy length, stall/overlap behaviour, mid-op reset and mthi/mtlo.
module tb_alu_md_ctrl;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] srca, srcb;
  logic [3:0]  alucontrol;
  logic        illegal, mdSel, stall, busy;
  logic [31:0] mdResult, hi, lo;

  int checks = 0;
  int errors = 0;
  int cycles;

  alu_md_ctrl #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_aluop(aluop), .i_funct(funct),
    .i_srca(srca), .i_srcb(srcb), .o_alucontrol(alucontrol), .o_illegal(illegal),
    .o_md_sel(mdSel), .o_md_result(mdResult), .o_stall(stall), .o_busy(busy),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b);
    en = e; aluop = op; funct = f; srca = a; srcb = b;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count the cycles busy stays high after the current edge, bounded.
  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Issue a mult/div while idle and run it to completion.
  task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    applyStimulus(1'b1, 2'b10, f, a, b);
    checkOutput("start_nostall", {63'd0, stall}, 64'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    waitIdle(n);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy",  {63'd0, busy},  64'd0);
    checkOutput("rst_stall", {63'd0, stall}, 64'd0);
    checkOutput("rst_hi",    {32'd0, hi},    64'd0);
    checkOutput("rst_lo",    {32'd0, lo},    64'd0);

    // Decoder table
    applyStimulus(1'b1, 2'b00, 6'd0, 32'd0, 32'd0);
    checkOutput("dec_add", {60'd0, alucontrol}, 64'h2);
    checkOutput("dec_add_ill", {63'd0, illegal}, 64'd0);
    applyStimulus(1'b1, 2'b01, 6'd0, 32'd0, 32'd0);
    checkOutput("dec_sub", {60'd0, alucontrol}, 64'h6);
    applyStimulus(1'b1, 2'b11, 6'd0, 32'd0, 32'd0);
    checkOutput("dec_or", {60'd0, alucontrol}, 64'h1);
    applyStimulus(1'b1, 2'b10, F_NOR, 32'd0, 32'd0);
    checkOutput("dec_nor", {60'd0, alucontrol}, 64'h4);
    applyStimulus(1'b1, 2'b10, F_SLTU, 32'd0, 32'd0);
    checkOutput("dec_sltu", {60'd0, alucontrol}, 64'h8);
    applyStimulus(1'b1, 2'b10, F_SRA, 32'd0, 32'd0);
    checkOutput("dec_sra", {60'd0, alucontrol}, 64'hB);
    applyStimulus(1'b1, 2'b10, 6'b111111, 32'd0, 32'd0);
    checkOutput("dec_bad", {60'd0, alucontrol}, 64'hF);
    checkOutput("dec_bad_ill", {63'd0, illegal}, 64'd1);
    // md funct decodes to none, not illegal; en=0 must not start it
    applyStimulus(1'b0, 2'b10, F_MULT, 32'd5, 32'd5);
    checkOutput("dec_md", {60'd0, alucontrol}, 64'hF);
    checkOutput("dec_md_ill", {63'd0, illegal}, 64'd0);
    tick();
    checkOutput("en0_nostart", {63'd0, busy}, 64'd0);

    // Multiply / divide results and busy length
    runOp(F_MULT, 32'hFFFFFFFE, 32'd3, cycles);
    checkOutput("mult_busy", cycles, 64'd33);
    checkOutput("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    checkOutput("mult_lo", {32'd0, lo}, 64'hFFFFFFFA);
    runOp(F_MULTU, 32'hFFFFFFFE, 32'd3, cycles);
    checkOutput("multu_hi", {32'd0, hi}, 64'h2);
    checkOutput("multu_lo", {32'd0, lo}, 64'hFFFFFFFA);
    runOp(F_DIV, 32'hFFFFFFF9, 32'd2, cycles);
    checkOutput("div_busy", cycles, 64'd33);
    checkOutput("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    checkOutput("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
    runOp(F_DIVU, 32'd7, 32'd0, cycles);
    checkOutput("divu0_lo", {32'd0, lo}, 64'hFFFFFFFF);
    checkOutput("divu0_hi", {32'd0, hi}, 64'h7);
    runOp(F_DIV, 32'hFFFFFFF9, 32'd0, cycles);
    checkOutput("div0_lo", {32'd0, lo}, 64'hFFFFFFFF);
    checkOutput("div0_hi", {32'd0, hi}, 64'hFFFFFFF9);
    runOp(F_DIV, 32'h80000000, 32'hFFFFFFFF, cycles);
    checkOutput("divovf_lo", {32'd0, lo}, 64'h80000000);
    checkOutput("divovf_hi", {32'd0, hi}, 64'h0);

    // mflo while busy stalls; an add issued mid-op does not
    applyStimulus(1'b1, 2'b10, F_MULT, 32'hFFFFFFFE, 32'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (5) tick();
    applyStimulus(1'b1, 2'b10, F_ADD, 32'd1, 32'd1);
    checkOutput("overlap_stall", {63'd0, stall}, 64'd0);
    checkOutput("overlap_busy", {63'd0, busy}, 64'd1);
    checkOutput("overlap_alu", {60'd0, alucontrol}, 64'h2);
    applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    checkOutput("mflo_stall", {63'd0, stall}, 64'd1);
    cycles = 0;
    while (stall && cycles < 200) begin
      cycles++;
      tick();
    end
    checkOutput("mflo_wait", cycles, 64'd28);
    checkOutput("mflo_nostall", {63'd0, stall}, 64'd0);
    checkOutput("mflo_sel", {63'd0, mdSel}, 64'd1);
    checkOutput("mflo_result", {32'd0, mdResult}, 64'hFFFFFFFA);
    applyStimulus(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    checkOutput("mfhi_result", {32'd0, mdResult}, 64'hFFFFFFFF);

    // Reset in the middle of RUN aborts the op and clears HI/LO
    applyStimulus(1'b1, 2'b10, F_MULTU, 32'd5, 32'd7);
    tick();
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_hi", {32'd0, hi}, 64'd0);
    checkOutput("midrst_lo", {32'd0, lo}, 64'd0);
    runOp(F_MULTU, 32'd5, 32'd7, cycles);
    checkOutput("postrst_busy", cycles, 64'd33);
    checkOutput("postrst_lo", {32'd0, lo}, 64'd35);
    checkOutput("postrst_hi", {32'd0, hi}, 64'd0);

    // mthi/mtlo and queued divu
    applyStimulus(1'b1, 2'b10, F_MTHI, 32'h1234, 32'd0);
    checkOutput("mthi_nostall", {63'd0, stall}, 64'd0);
    tick();
    checkOutput("mthi_hi", {32'd0, hi}, 64'h1234);
    applyStimulus(1'b1, 2'b10, F_MTLO, 32'h5678, 32'd0);
    tick();
    checkOutput("mtlo_lo", {32'd0, lo}, 64'h5678);
    applyStimulus(1'b0, 2'b10, F_MTHI, 32'hFFFF, 32'd0);
    tick();
    checkOutput("mthi_en0", {32'd0, hi}, 64'h1234);
    applyStimulus(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b1, 2'b10, F_MTHI, 32'hDEAD, 32'd0);
    checkOutput("mthi_busy_stall", {63'd0, stall}, 64'd1);
    tick();
    checkOutput("mthi_busy_hi", {32'd0, hi}, 64'h1234);
    applyStimulus(1'b1, 2'b10, F_DIVU, 32'd53, 32'd5);
    checkOutput("divu_q_stall", {63'd0, stall}, 64'd1);
    cycles = 0;
    while (stall && cycles < 200) begin
      cycles++;
      tick();
    end
    checkOutput("divu_q_busy", {63'd0, busy}, 64'd0);
    checkOutput("divu1_lo", {32'd0, lo}, 64'd14);
    checkOutput("divu1_hi", {32'd0, hi}, 64'd2);
    tick();
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    checkOutput("divu_q_accept", {63'd0, busy}, 64'd1);
    waitIdle(cycles);
    checkOutput("divu2_busy", cycles, 64'd33);
    checkOutput("divu2_lo", {32'd0, lo}, 64'd10);
    checkOutput("divu2_hi", {32'd0, hi}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
